// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor carrier / direction interlock slice.
package ac_motor_pkg;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN_CW  = 2'd1,
    ST_RUN_CCW = 2'd2,
    ST_DEAD    = 2'd3
  } ch_state_t;

  typedef enum logic [1:0] {
    REQ_STOP = 2'd0,
    REQ_CW   = 2'd1,
    REQ_CCW  = 2'd2
  } dir_req_t;

  localparam logic MODE_SYM = 1'b0;
  localparam logic MODE_SAW = 1'b1;

  localparam int DEFAULT_HALF_C  = 4100;
  localparam int DEFAULT_SCALE_C = 2046;

  // Conflicting requests (both or neither) decode to stop.
  function automatic dir_req_t decode_req(input logic cw, input logic ccw);
    if (cw && !ccw)      return REQ_CW;
    else if (ccw && !cw) return REQ_CCW;
    else                 return REQ_STOP;
  endfunction

  function automatic ch_state_t run_state(input dir_req_t req);
    case (req)
      REQ_CW:  return ST_RUN_CW;
      REQ_CCW: return ST_RUN_CCW;
      default: return ST_STOP;
    endcase
  endfunction

endpackage

// File: rtl/ac_motor_dir_interlock.sv
// Per-channel CW/CCW latch that only moves on carrier peaks and inserts a dead interval on reversal.
module ac_motor_dir_interlock
  import ac_motor_pkg::*;
#(
  parameter int DEAD_PERIODS = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic PEAK,
  input  logic CW_REQ,
  input  logic CCW_REQ,
  output logic CW,
  output logic CCW
);

  localparam int DW = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  ch_state_t      state, state_nxt;
  logic [DW-1:0]  dcnt, dcnt_nxt;
  dir_req_t       req;

  assign req = decode_req(CW_REQ, CCW_REQ);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if (PEAK) begin
      case (state)
        ST_STOP: state_nxt = run_state(req);
        ST_RUN_CW: begin
          if (req == REQ_CCW) begin
            state_nxt = ST_DEAD;
            dcnt_nxt  = DW'(DEAD_PERIODS);
          end else if (req == REQ_STOP) begin
            state_nxt = ST_STOP;
          end
        end
        ST_RUN_CCW: begin
          if (req == REQ_CW) begin
            state_nxt = ST_DEAD;
            dcnt_nxt  = DW'(DEAD_PERIODS);
          end else if (req == REQ_STOP) begin
            state_nxt = ST_STOP;
          end
        end
        default: begin
          if (dcnt == '0) state_nxt = run_state(req);
          else            dcnt_nxt  = dcnt - 1'b1;
        end
      endcase
    end
  end

  // Outputs are flopped from the next state so they switch on the same edge as LOCK.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_STOP;
      dcnt  <= '0;
      CW    <= 1'b0;
      CCW   <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      CW    <= (state_nxt == ST_RUN_CW);
      CCW   <= (state_nxt == ST_RUN_CCW);
    end
  end

endmodule

// File: rtl/ac_motor_carrier_mc.sv
// Shared scaled PWM carrier (triangle or sawtooth) with peak-synchronous reload and per-channel direction interlocks.
module ac_motor_carrier_mc
  import ac_motor_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int CNT_BITS      = 16,
  parameter int DEFAULT_HALF  = DEFAULT_HALF_C,
  parameter int DEFAULT_SCALE = DEFAULT_SCALE_C,
  parameter int DEAD_PERIODS  = 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [CNT_BITS-1:0]        HALF_PERIOD,
  input  logic [15:0]                SCALE,
  input  logic                       MODE,
  input  logic [CHANNELS-1:0]        CW_IN,
  input  logic [CHANNELS-1:0]        CCW_IN,
  output logic signed [CNT_BITS+17:0] TRIANGLE,
  output logic                       LOCK,
  output logic [CHANNELS-1:0]        CW_OUT,
  output logic [CHANNELS-1:0]        CCW_OUT
);

  localparam int CW_W = CNT_BITS + 1;
  localparam int PW   = CNT_BITS + 18;
  localparam logic signed [CW_W-1:0] ONE = CW_W'(1);

  function automatic logic [CNT_BITS-1:0] clamp_half(input logic [CNT_BITS-1:0] h);
    return (h == '0) ? CNT_BITS'(1) : h;
  endfunction

  logic signed [CW_W-1:0] count_p0, count_nxt;
  logic                   rising_p0, rising_nxt;
  logic [CNT_BITS-1:0]    half_act, half_new;
  logic [15:0]            scale_act;
  logic                   mode_act;
  logic signed [CW_W-1:0] half_s, half_new_s;
  logic                   peak_p0;
  logic signed [PW-1:0]   cnt_ext, scl_ext;

  assign half_new   = clamp_half(HALF_PERIOD);
  assign half_s     = $signed({1'b0, half_act});
  assign half_new_s = $signed({1'b0, half_new});
  assign peak_p0    = (count_p0 >= half_s) && (rising_p0 || (mode_act == MODE_SAW));

  // At a peak the incoming mode decides the next step; otherwise the active mode does.
  always_comb begin
    count_nxt  = count_p0;
    rising_nxt = rising_p0;
    if (peak_p0) begin
      if (MODE == MODE_SAW) begin
        count_nxt  = -half_new_s;
        rising_nxt = 1'b1;
      end else begin
        count_nxt  = count_p0 - ONE;
        rising_nxt = 1'b0;
      end
    end else if (mode_act == MODE_SAW || rising_p0) begin
      count_nxt = count_p0 + ONE;
    end else if (count_p0 <= -half_s) begin
      count_nxt  = count_p0 + ONE;
      rising_nxt = 1'b1;
    end else begin
      count_nxt = count_p0 - ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_p0  <= '0;
      rising_p0 <= 1'b1;
      half_act  <= CNT_BITS'(DEFAULT_HALF);
      scale_act <= 16'(DEFAULT_SCALE);
      mode_act  <= MODE_SYM;
    end else begin
      count_p0  <= count_nxt;
      rising_p0 <= rising_nxt;
      if (peak_p0) begin
        half_act  <= half_new;
        scale_act <= SCALE;
        mode_act  <= MODE;
      end
    end
  end

  // ---- p0 -> p1: scale the count; LOCK travels with the peak sample ----
  assign cnt_ext = PW'(count_p0);
  assign scl_ext = $signed(PW'({1'b0, scale_act}));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      TRIANGLE <= '0;
      LOCK     <= 1'b0;
    end else begin
      TRIANGLE <= cnt_ext * scl_ext;
      LOCK     <= peak_p0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    ac_motor_dir_interlock #(
      .DEAD_PERIODS(DEAD_PERIODS)
    ) u_dir (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .PEAK   (peak_p0),
      .CW_REQ (CW_IN[k]),
      .CCW_REQ(CCW_IN[k]),
      .CW     (CW_OUT[k]),
      .CCW    (CCW_OUT[k])
    );
  end

endmodule
